// File: rtl/ram_pkg.sv
// Shared types and helpers for the two-port RAM controller.
// Holds the FSM state type and the byte-enable merge.
package ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  // Widest word the merge helper handles; callers size-cast to their width.
  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  // Byte-enable lanes for a given word width.
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  // Index bits needed to address depth words (at least one).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Replace the bytes of old_w selected by be with those of new_w.
  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dual_port_ram_ctrl_rd_stage.sv
// Per-port read return stage: registers read data, valid and
// out-of-range error one cycle after an accepted access.
module ram_rd_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_i,
  input  logic          rd_i,
  input  logic          oor_i,
  input  logic [DW-1:0] data_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o
);

  logic          rvalid_d, rvalid_q;
  logic [DW-1:0] rdata_d, rdata_q;
  logic          err_d, err_q;

  // Next-state: data captured only on an accepted read, else held.
  always_comb begin
    rvalid_d = acc_i && rd_i;
    rdata_d  = rvalid_d ? data_i : rdata_q;
    err_d    = acc_i && oor_i;
  end

  // Return registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Two-port RAM controller: shared array, byte-enable writes,
// read-first 1-cycle reads, A-wins write collisions, optional clear.
module dual_port_ram_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1 << ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_err,
  output logic                    init_done
);

  localparam int BW = be_width(DATA_WIDTH);
  localparam int IW = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam state_e RST_ST = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e        state_d, state_q;
  logic [IW-1:0] cnt_d, cnt_q;
  logic          done_d, done_q;

  logic                  run, clr_we, collide;
  logic                  a_in, b_in, a_acc, b_acc;
  logic [IW-1:0]         a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_rd, b_rd;
  logic [DATA_WIDTH-1:0] a_mrg, b_mrg;
  logic [BW-1:0]         a_be_w, b_be_w;

  assign a_be_w = a_be;
  assign b_be_w = b_be;

  // Address decode, grant and collision logic; grants die with rst.
  always_comb begin
    run     = (state_q == ST_RUN) && !rst;
    clr_we  = (state_q == ST_INIT) && !rst;
    a_in    = {1'b0, a_addr} < DEPTH_W;
    b_in    = {1'b0, b_addr} < DEPTH_W;
    collide = a_req && b_req && a_we && b_we
              && a_in && b_in && (a_addr == b_addr);
    a_gnt   = run;
    b_gnt   = run && !collide;
    a_acc   = a_req && a_gnt;
    b_acc   = b_req && b_gnt;
    a_idx   = a_addr[IW-1:0];
    b_idx   = b_addr[IW-1:0];
    a_old   = mem_q[a_idx];
    b_old   = mem_q[b_idx];
    a_rd    = a_in ? a_old : '0;
    b_rd    = b_in ? b_old : '0;
    a_mrg   = DATA_WIDTH'(be_merge(MAX_DW'(a_old), MAX_DW'(a_wdata),
                                   MAX_BE'(a_be_w)));
    b_mrg   = DATA_WIDTH'(be_merge(MAX_DW'(b_old), MAX_DW'(b_wdata),
                                   MAX_BE'(b_be_w)));
  end

  // Array writes: clear word, then port writes (never same word).
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[cnt_q] <= '0;
    if (a_acc && a_we && a_in) mem_q[a_idx] <= a_mrg;
    if (b_acc && b_we && b_in) mem_q[b_idx] <= b_mrg;
  end

  // FSM next state: sweep clear counter, then run forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: done_d = 1'b1;
    endcase
  end

  // FSM registers with registered init_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign init_done = done_q;

  ram_rd_stage #(.DW(DATA_WIDTH)) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .acc_i    (a_acc),
    .rd_i     (!a_we),
    .oor_i    (!a_in),
    .data_i   (a_rd),
    .rvalid_o (a_rvalid),
    .rdata_o  (a_rdata),
    .err_o    (a_err)
  );

  ram_rd_stage #(.DW(DATA_WIDTH)) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .acc_i    (b_acc),
    .rd_i     (!b_we),
    .oor_i    (!b_in),
    .data_i   (b_rd),
    .rvalid_o (b_rvalid),
    .rdata_o  (b_rdata),
    .err_o    (b_err)
  );

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Bench for dual_port_ram_ctrl: directed table, random vs model,
// reset during clear and during run.
module tb_dual_port_ram_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 200;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } port_t;

  typedef struct packed {
    port_t       a;
    port_t       b;
    logic        ga;
    logic        gb;
    logic        arv;
    logic [31:0] ard;
    logic        aerr;
    logic        brv;
    logic [31:0] brd;
    logic        berr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0] a_be = 0, b_be = 0;
  logic [AW-1:0] a_addr = 0, b_addr = 0;
  logic [DW-1:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, init_done;
  logic [DW-1:0] a_rdata, b_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [256];
  logic [31:0] m_ard, m_brd;

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err),
    .init_done(init_done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic port_t wr(input logic [3:0] be, input logic [7:0] ad,
                               input logic [31:0] d);
    return '{req: 1'b1, we: 1'b1, be: be, addr: ad, wdata: d};
  endfunction

  function automatic port_t rd(input logic [7:0] ad);
    return '{req: 1'b1, we: 1'b0, be: 4'h0, addr: ad, wdata: 32'h0};
  endfunction

  function automatic vec_t mk(input port_t a, input port_t b,
    input logic ga, input logic gb,
    input logic arv, input logic [31:0] ard, input logic aerr,
    input logic brv, input logic [31:0] brd, input logic berr);
    return '{a: a, b: b, ga: ga, gb: gb, arv: arv, ard: ard, aerr: aerr,
             brv: brv, brd: brd, berr: berr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input port_t a, input port_t b);
    a_req = a.req; a_we = a.we; a_be = a.be;
    a_addr = a.addr; a_wdata = a.wdata;
    b_req = b.req; b_we = b.we; b_be = b.be;
    b_addr = b.addr; b_wdata = b.wdata;
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    m_ard = 32'h0;
    m_brd = 32'h0;
  endtask

  // Memory as a plain array: reads see the old word, A writes before B.
  task automatic model_step(input port_t a, input port_t b,
    output logic ga, output logic gb,
    output logic arv, output logic aerr,
    output logic brv, output logic berr);
    bit a_ok, b_ok;
    a_ok = int'(a.addr) < DEPTH;
    b_ok = int'(b.addr) < DEPTH;
    ga = 1'b1;
    gb = !(a.req && b.req && a.we && b.we && a_ok && a.addr == b.addr);
    arv  = a.req && !a.we;
    aerr = a.req && !a_ok;
    brv  = b.req && gb && !b.we;
    berr = b.req && gb && !b_ok;
    if (arv) m_ard = a_ok ? mdl[a.addr] : 32'h0;
    if (brv) m_brd = b_ok ? mdl[b.addr] : 32'h0;
    if (a.req && a.we && a_ok)
      for (int k = 0; k < 4; k++)
        if (a.be[k]) mdl[a.addr][8*k +: 8] = a.wdata[8*k +: 8];
    if (b.req && gb && b.we && b_ok)
      for (int k = 0; k < 4; k++)
        if (b.be[k]) mdl[b.addr][8*k +: 8] = b.wdata[8*k +: 8];
  endtask

  task automatic wait_init(input string nm);
    int n;
    logic gl;
    n  = 0;
    gl = 1'b0;
    drive(rd(8'h00), rd(8'h00));
    while (n < 1000) begin
      cyc();
      n++;
      if (init_done) break;
      if (a_gnt || b_gnt) gl = 1'b1;
    end
    chk({nm, "_cycles"}, n, DEPTH);
    chk({nm, "_gnt_low"}, {31'h0, gl}, 32'h0);
    chk({nm, "_gnt_up"}, {31'h0, a_gnt}, 32'h1);
    drive('0, '0);
    cyc();
    model_clear();
  endtask

  vec_t tbl [16];

  initial begin
    logic ga, gb, arv, aerr, brv, berr;
    port_t pa, pb;
    port_t nn;
    logic [7:0] alist [8];
    nn = '0;
    alist = '{8'h05, 8'h07, 8'h09, 8'h10, 8'hC7, 8'hC8, 8'hFF, 8'h00};

    tbl[0]  = mk(wr(4'hF, 8'h05, 32'h1234_5678), nn, 1,1, 0,0,0, 0,0,0);
    tbl[1]  = mk(wr(4'h2, 8'h05, 32'hFFFF_AB00), nn, 1,1, 0,0,0, 0,0,0);
    tbl[2]  = mk(nn, rd(8'h05), 1,1, 0,0,0, 1,32'h1234_AB78,0);
    tbl[3]  = mk(wr(4'hF, 8'h07, 32'hDEAD_BEEF),
                 wr(4'hF, 8'h07, 32'hCAFE_0000), 1,0, 0,0,0, 0,0,0);
    tbl[4]  = mk(nn, wr(4'hF, 8'h07, 32'hCAFE_0000), 1,1, 0,0,0, 0,0,0);
    tbl[5]  = mk(rd(8'h07), nn, 1,1, 1,32'hCAFE_0000,0, 0,0,0);
    tbl[6]  = mk(wr(4'hF, 8'h09, 32'h1111_1111), rd(8'h09),
                 1,1, 0,0,0, 1,32'h0,0);
    tbl[7]  = mk(nn, rd(8'h09), 1,1, 0,0,0, 1,32'h1111_1111,0);
    tbl[8]  = mk(rd(8'hC8), nn, 1,1, 1,32'h0,1, 0,0,0);
    tbl[9]  = mk(wr(4'hF, 8'hC8, 32'hFFFF_FFFF),
                 wr(4'hF, 8'hC8, 32'hFFFF_FFFF), 1,1, 0,0,1, 0,0,1);
    tbl[10] = mk(rd(8'hC8), rd(8'h05), 1,1, 1,32'h0,1,
                 1,32'h1234_AB78,0);
    tbl[11] = mk(wr(4'h0, 8'h09, 32'h0), rd(8'h09), 1,1, 0,0,0,
                 1,32'h1111_1111,0);
    tbl[12] = mk(rd(8'h09), nn, 1,1, 1,32'h1111_1111,0, 0,0,0);
    tbl[13] = mk(rd(8'hFF), nn, 1,1, 1,32'h0,1, 0,0,0);
    tbl[14] = mk(rd(8'hC7), wr(4'h1, 8'hC7, 32'hA5A5_A5A5),
                 1,1, 1,32'h0,0, 0,0,0);
    tbl[15] = mk(rd(8'hC7), nn, 1,1, 1,32'h0000_00A5,0, 0,0,0);

    // Reset values with requests pending.
    drive(rd(8'h10), rd(8'h10));
    chk("rst_a_gnt", {31'h0, a_gnt}, 0);
    chk("rst_b_gnt", {31'h0, b_gnt}, 0);
    chk("rst_rvalid", {30'h0, a_rvalid, b_rvalid}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_err", {30'h0, a_err, b_err}, 0);
    chk("rst_init_done", {31'h0, init_done}, 0);
    cyc();
    cyc();

    // Reset partway through the clear sweep.
    rst = 1'b0;
    for (int i = 0; i < 100; i++) cyc();
    chk("mid_init_gnt_low", {31'h0, a_gnt}, 0);
    rst = 1'b1;
    #1;
    chk("mid_init_rst_done", {31'h0, init_done}, 0);
    chk("mid_init_rst_gnt", {30'h0, a_gnt, b_gnt}, 0);
    cyc();
    rst = 1'b0;
    wait_init("init1");

    // Cleared array reads zero.
    drive(rd(8'h10), nn);
    cyc();
    chk("clr_rvalid", {31'h0, a_rvalid}, 1);
    chk("clr_rdata", a_rdata, 32'h0);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].a, tbl[i].b);
      model_step(tbl[i].a, tbl[i].b, ga, gb, arv, aerr, brv, berr);
      chk($sformatf("t%0d_a_gnt", i), {31'h0, a_gnt}, {31'h0, tbl[i].ga});
      chk($sformatf("t%0d_b_gnt", i), {31'h0, b_gnt}, {31'h0, tbl[i].gb});
      cyc();
      chk($sformatf("t%0d_a_rv", i), {31'h0, a_rvalid},
          {31'h0, tbl[i].arv});
      if (tbl[i].arv)
        chk($sformatf("t%0d_a_rd", i), a_rdata, tbl[i].ard);
      chk($sformatf("t%0d_a_err", i), {31'h0, a_err}, {31'h0, tbl[i].aerr});
      chk($sformatf("t%0d_b_rv", i), {31'h0, b_rvalid},
          {31'h0, tbl[i].brv});
      if (tbl[i].brv)
        chk($sformatf("t%0d_b_rd", i), b_rdata, tbl[i].brd);
      chk($sformatf("t%0d_b_err", i), {31'h0, b_err}, {31'h0, tbl[i].berr});
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      pa.req   = ($urandom_range(0, 3) != 0);
      pa.we    = $urandom_range(0, 1) != 0;
      pa.be    = 4'($urandom);
      pa.addr  = alist[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) pa.addr = 8'($urandom);
      pa.wdata = $urandom;
      pb.req   = ($urandom_range(0, 3) != 0);
      pb.we    = $urandom_range(0, 1) != 0;
      pb.be    = 4'($urandom);
      pb.addr  = alist[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) pb.addr = 8'($urandom);
      pb.wdata = $urandom;
      drive(pa, pb);
      model_step(pa, pb, ga, gb, arv, aerr, brv, berr);
      chk("rnd_a_gnt", {31'h0, a_gnt}, {31'h0, ga});
      chk("rnd_b_gnt", {31'h0, b_gnt}, {31'h0, gb});
      cyc();
      chk("rnd_a_rv", {31'h0, a_rvalid}, {31'h0, arv});
      chk("rnd_a_rd", a_rdata, m_ard);
      chk("rnd_a_err", {31'h0, a_err}, {31'h0, aerr});
      chk("rnd_b_rv", {31'h0, b_rvalid}, {31'h0, brv});
      chk("rnd_b_rd", b_rdata, m_brd);
      chk("rnd_b_err", {31'h0, b_err}, {31'h0, berr});
    end

    // Reset mid-run with a read in flight.
    drive(rd(8'h05), rd(8'h07));
    rst = 1'b1;
    #1;
    chk("run_rst_gnt", {30'h0, a_gnt, b_gnt}, 0);
    chk("run_rst_rdata", a_rdata | b_rdata, 0);
    chk("run_rst_done", {31'h0, init_done}, 0);
    cyc();
    chk("run_rst_rvalid", {30'h0, a_rvalid, b_rvalid}, 0);
    rst = 1'b0;
    wait_init("init2");
    drive(nn, rd(8'h05));
    cyc();
    chk("reclr_rvalid", {31'h0, b_rvalid}, 1);
    chk("reclr_rdata", b_rdata, 32'h0);
    drive(nn, nn);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_ctrl.md
# dual_port_ram_ctrl

Parametrised two-port successor to the processor's single-port program/data RAM. Two independent request/grant ports (A: CPU data side, B: SPI loader/DMA side) share one storage array with byte-enable writes, registered 1-cycle reads, deterministic collision arbitration and an optional hardware clear sequence after reset. It sits between the processor core and the SPI front end and replaces the single-port memory where both need concurrent access.

## Interface
- ADDR_WIDTH, 8, address bits per port
- DATA_WIDTH, 32, word width; must be a multiple of 8
- DEPTH, 1 << ADDR_WIDTH, number of words; may be smaller than 2^ADDR_WIDTH
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before granting access
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- x_req  in  1  request, for x in {a, b}
- x_we  in  1  1 = write, 0 = read
- x_be  in  DATA_WIDTH/8  byte enables, write only; bit i covers bits [8i+7:8i]
- x_addr  in  ADDR_WIDTH  word address
- x_wdata  in  DATA_WIDTH  write data
- x_gnt  out  1  request accepted this cycle (combinational)
- x_rvalid  out  1  one-cycle pulse, read data valid
- x_rdata  out  DATA_WIDTH  read data, held until next read completes
- x_err  out  1  pulse, accepted access had x_addr >= DEPTH
- init_done  out  1  high once array is usable

## Operation
- FSM states: INIT, RUN. Reset → INIT if CLEAR_ON_RESET=1, else RUN.
- INIT: counter 0..DEPTH-1 writes zero to one word per cycle; after word DEPTH-1 → RUN. Both gnt low throughout.
- RUN: transfer occurs when x_req && x_gnt. a_gnt = 1. b_gnt = 1 except collision: both req, both we, same in-range addr → b_gnt = 0 (B stalls, must hold request; A wins).
- Write: only bytes with x_be[i]=1 updated; x_be = 0 is an accepted no-op. No rvalid for writes.
- Read: x_rdata/x_rvalid registered one cycle after acceptance. Read-first: read and write to same address in same cycle (either port pairing) returns pre-write data.
- Out-of-range (addr >= DEPTH): write discarded, read returns 0 with rvalid; x_err pulses the cycle after acceptance (aligned with rvalid for reads).
- Storage contents are not touched by reset when CLEAR_ON_RESET=0.
- Reset mid-INIT or mid-RUN: state, counter and all outputs return to reset values immediately; in-flight read lost (no rvalid); clear restarts at word 0.

## Timing
- Reset values: all x_gnt 0, x_rvalid 0, x_rdata 0, x_err 0, init_done 0; gnt forced 0 while rst high.
- init_done: CLEAR_ON_RESET=1 → rises DEPTH cycles after first clk edge with rst low; CLEAR_ON_RESET=0 → rises on first edge after rst low. Never falls except on reset.
- Read latency 1 cycle, throughput 1 access/cycle/port; back-to-back reads give back-to-back rvalid.
- Write visible to reads accepted on the following cycle or later.
- Stalled B retry completes the cycle after A's conflicting write, sees A's data if B is then read (n/a) or overwrites it (B write lands last).

## Structure
- Package ram_pkg: state enum (INIT, RUN), BE-merge function (old word, new word, be → merged word), shared width helpers.
- Sub-module ram_rd_stage (instantiated per port): registers rdata, rvalid, err; async reset.
- Top holds array, FSM, clear counter, collision/grant logic.

## Test plan
- Reset release, CLEAR_ON_RESET=1, DEPTH=256 → gnt low 256 cycles, init_done rises cycle 256, read of addr 0x10 returns 0x0000_0000.
- A write 0x1234_5678 be=4'b1111 to 0x05, then be=4'b0010 data 0xFFFF_AB00 → B read 0x05 returns 0x1234_AB78 one cycle after grant.
- Same cycle A write 0xDEAD_BEEF and B write 0xCAFE_0000 to 0x07 → b_gnt 0 that cycle, B lands next cycle; final read 0x07 = 0xCAFE_0000.
- A write 0x1111_1111 and B read same addr 0x09 (old 0x0) same cycle → b_rdata 0x0, next B read 0x1111_1111.
- DEPTH=200, A read 0xC8 → a_rvalid=1, a_rdata=0, a_err=1; write to 0xC8 changes nothing.
- rst asserted at INIT counter 100 → outputs zero immediately; after release clear restarts from 0, init_done after full DEPTH cycles.
